// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B4 classic master issuing single and incrementing-burst transfers.
// Optional ack watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_burst_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_BURST      = 8,
  parameter int LEN_WIDTH      = $clog2(MAX_BURST + 1),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  input  logic                  cmd_tag_add_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  done_o,
  output logic                  cmd_err_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  output logic                  tag_add_o,
  output logic [2:0]            cti_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i
);
  typedef enum logic [2:0] {IDLE, LOAD, BUS, GAP, DONE} state_t;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef WB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  state_t                state_q, state_d;
  logic                  we_q, we_d, tag_q, tag_d, stb_q, stb_d, cyc_q, cyc_d;
  logic                  rd_valid_q, rd_valid_d, done_q, done_d, cmd_err_q, cmd_err_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, beat_q, beat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rd_data_q, rd_data_d;
  logic [2:0]            cti_q, cti_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  last, timeout, abort, next_wr;
  assign last        = beat_q == len_q - 1'b1;
  assign timeout     = TO_EN && stb_q && !ack_i && !err_i && wd_q == WD_W'(TIMEOUT_CYCLES - 1);
  assign abort       = err_i || timeout;
  assign next_wr     = we_q && ack_i && !abort && !last && wr_valid_i;
  assign cmd_ready_o = state_q == IDLE;
  assign wr_ready_o  = (state_q == LOAD && wr_valid_i) || (state_q == BUS && next_wr);
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign sel_o       = sel_q;
  assign we_o        = we_q;
  assign stb_o       = stb_q;
  assign cyc_o       = cyc_q;
  assign tag_add_o   = tag_q;
  assign cti_o       = cti_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign done_o      = done_q;
  assign cmd_err_o   = cmd_err_q;
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    tag_d      = tag_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    sel_d      = sel_q;
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    cmd_err_d  = 1'b0;
    wd_d       = '0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        we_d   = cmd_we_i;
        addr_d = cmd_addr_i;
        len_d  = cmd_len_i;
        sel_d  = cmd_sel_i;
        tag_d  = cmd_tag_add_i;
        beat_d = '0;
        err_d  = cmd_len_i == '0 || cmd_len_i > LEN_WIDTH'(MAX_BURST);
        if (err_d) state_d = DONE;
        else begin
          cyc_d   = 1'b1;
          stb_d   = !cmd_we_i;
          state_d = cmd_we_i ? LOAD : BUS;
        end
      end
      LOAD: if (wr_valid_i) begin
        data_d  = wr_data_i;
        stb_d   = 1'b1;
        state_d = BUS;
      end
      BUS: begin
        wd_d = wd_q + 1'b1;
        if (abort) begin
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (ack_i) begin
          wd_d       = '0;
          beat_d     = beat_q + 1'b1;
          addr_d     = addr_q + 1'b1;
          rd_valid_d = !we_q;
          if (!we_q) rd_data_d = data_i;
          // A classic single beat detours through GAP so a registered ack is not seen twice
          if (last) begin
            stb_d   = 1'b0;
            cyc_d   = 1'b0;
            state_d = len_q == LEN_WIDTH'(1) ? GAP : DONE;
          end else if (we_q && !wr_valid_i) begin
            stb_d   = 1'b0;
            state_d = LOAD;
          end else if (we_q) data_d = wr_data_i;
        end
      end
      GAP: state_d = DONE;
      DONE: begin
        done_d    = 1'b1;
        cmd_err_d = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cti_d = (!stb_d || len_d == LEN_WIDTH'(1)) ? 3'b000 : (beat_d == len_d - 1'b1) ? 3'b111 : 3'b010;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      tag_q      <= 1'b0;
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      rd_data_q  <= '0;
      cti_q      <= 3'b000;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      tag_q      <= tag_d;
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      rd_data_q  <= rd_data_d;
      cti_q      <= cti_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      cmd_err_q  <= cmd_err_d;
      wd_q       <= wd_d;
    end
  end
endmodule
